// File: rtl/pkg_tpu.sv
// Shared types and constants for the TPU lane bypass-slice sequencer.
//   seq_state_t : sequencer FSM states
//   seq_cmd_t   : latched vector command (source enables, bases, destination, length)
//   SEQ_*       : default widths and in-flight credit limit
package pkg_tpu;

   localparam int SEQ_IDX_W        = 8;
   localparam int SEQ_LEN_W        = 8;
   localparam int SEQ_MAX_INFLIGHT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } seq_state_t;

   // The field widths follow the package defaults. The top module narrows
   // or widens fields with explicit casts, so its parameters stay overridable.
   typedef struct packed {
      logic [2:0]           src_en;
      logic [SEQ_IDX_W-1:0] base1;
      logic [SEQ_IDX_W-1:0] base2;
      logic [SEQ_IDX_W-1:0] base3;
      logic [SEQ_IDX_W-1:0] dst;
      logic [SEQ_LEN_W-1:0] len;
   } seq_cmd_t;

endpackage

// File: rtl/credit_counter.sv
// Up/down counter of issued-but-not-retired elements.
//   clock, reset  : clock and synchronous active-high reset
//   inc_i         : one element issued this cycle
//   dec_i         : one element write-back retired this cycle
//   count_o       : current outstanding count
//   avail_o       : count below the credit limit MAX
//   next_zero_o   : count will be zero after this edge
//   underflow_o   : sticky flag, set by a retire with nothing outstanding
module credit_counter #(
   parameter int MAX = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   inc_i,
   input  logic                   dec_i,
   output logic [$clog2(MAX):0]   count_o,
   output logic                   avail_o,
   output logic                   next_zero_o,
   output logic                   underflow_o
);

   localparam int CW = $clog2(MAX) + 1;

   logic [CW-1:0] count_q, count_d;
   logic          underflow_q, underflow_d;

   always_comb begin
      count_d     = count_q;
      underflow_d = underflow_q;
      if (inc_i && !dec_i) begin
         count_d = count_q + CW'(1);
      end else if (!inc_i && dec_i) begin
         // A retire with nothing outstanding is an error; the count pins at zero.
         if (count_q == '0) begin
            underflow_d = 1'b1;
         end else begin
            count_d = count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q     <= '0;
         underflow_q <= 1'b0;
      end else begin
         count_q     <= count_d;
         underflow_q <= underflow_d;
      end
   end

   assign count_o     = count_q;
   assign avail_o     = (count_q < CW'(MAX));
   assign next_zero_o = (count_d == '0);
   assign underflow_o = underflow_q;

endmodule

// File: rtl/bypass_slice_seq.sv
// Sequences one vector slice command through the bypass buffer / register-read
// path of a TPU lane, emitting one element (source and destination indices) per
// cycle. Issue is throttled by force-stall, buffer-full and an in-flight credit
// limit; a new command is held off until every write-back of the current one
// has retired.
//   clock, reset             : clock, synchronous active-high reset
//   I_Cmd_*, O_Cmd_Ready      : command handshake and fields
//   I_Stall, I_Full           : issue throttles
//   I_WB_Done                 : one element write-back retired
//   O_IdxK_V/O_IdxK (K=1..3)  : per-source read index and valid
//   O_Dst_V/O_Dst             : destination index, valid on every issue
//   O_Slice_Len               : command length tag on the first element only
//   O_Busy, O_Inflight        : status
//   O_Underflow               : sticky retire-without-outstanding error
module bypass_slice_seq
   import pkg_tpu::*;
#(
   parameter int WIDTH_IDX    = SEQ_IDX_W,
   parameter int WIDTH_LEN    = SEQ_LEN_W,
   parameter int MAX_INFLIGHT = SEQ_MAX_INFLIGHT
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          I_Cmd_Valid,
   output logic                          O_Cmd_Ready,
   input  logic [2:0]                    I_Cmd_Src_En,
   input  logic [WIDTH_IDX-1:0]          I_Cmd_Base1,
   input  logic [WIDTH_IDX-1:0]          I_Cmd_Base2,
   input  logic [WIDTH_IDX-1:0]          I_Cmd_Base3,
   input  logic [WIDTH_IDX-1:0]          I_Cmd_Dst,
   input  logic [WIDTH_LEN-1:0]          I_Cmd_Len,
   input  logic                          I_Stall,
   input  logic                          I_Full,
   input  logic                          I_WB_Done,
   output logic                          O_Idx1_V,
   output logic                          O_Idx2_V,
   output logic                          O_Idx3_V,
   output logic [WIDTH_IDX-1:0]          O_Idx1,
   output logic [WIDTH_IDX-1:0]          O_Idx2,
   output logic [WIDTH_IDX-1:0]          O_Idx3,
   output logic                          O_Dst_V,
   output logic [WIDTH_IDX-1:0]          O_Dst,
   output logic [WIDTH_LEN-1:0]          O_Slice_Len,
   output logic                          O_Busy,
   output logic [$clog2(MAX_INFLIGHT):0] O_Inflight,
   output logic                          O_Underflow
);

   seq_state_t           state_q, state_d;
   seq_cmd_t             cmd_q, cmd_d;
   logic [WIDTH_LEN-1:0] cnt_q, cnt_d;

   logic                 credit_avail;
   logic                 next_zero;
   logic                 issue;
   logic [WIDTH_LEN-1:0] len;
   logic [WIDTH_IDX-1:0] cnt_idx;
   logic [2:0][WIDTH_IDX-1:0] src_base;
   logic [2:0][WIDTH_IDX-1:0] src_idx;
   logic [2:0]                src_v;

   assign len     = WIDTH_LEN'(cmd_q.len);
   assign cnt_idx = WIDTH_IDX'(cnt_q);

   // A retire in the same cycle frees a credit, so a full window can still issue.
   assign issue = (state_q == RUN) && !I_Stall && !I_Full && (credit_avail || I_WB_Done);

   credit_counter #(
      .MAX (MAX_INFLIGHT)
   ) u_credit (
      .clock       (clock),
      .reset       (reset),
      .inc_i       (issue),
      .dec_i       (I_WB_Done),
      .count_o     (O_Inflight),
      .avail_o     (credit_avail),
      .next_zero_o (next_zero),
      .underflow_o (O_Underflow)
   );

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (I_Cmd_Valid) begin
               state_d      = RUN;
               cmd_d.src_en = I_Cmd_Src_En;
               cmd_d.base1  = SEQ_IDX_W'(I_Cmd_Base1);
               cmd_d.base2  = SEQ_IDX_W'(I_Cmd_Base2);
               cmd_d.base3  = SEQ_IDX_W'(I_Cmd_Base3);
               cmd_d.dst    = SEQ_IDX_W'(I_Cmd_Dst);
               cmd_d.len    = SEQ_LEN_W'(I_Cmd_Len);
               cnt_d        = '0;
            end
         end
         RUN: begin
            if (issue) begin
               cnt_d = cnt_q + WIDTH_LEN'(1);
               if (cnt_q == len) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (next_zero) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign src_base[0] = WIDTH_IDX'(cmd_q.base1);
   assign src_base[1] = WIDTH_IDX'(cmd_q.base2);
   assign src_base[2] = WIDTH_IDX'(cmd_q.base3);

   // Index adders wrap modulo 2^WIDTH_IDX; indices read as zero when idle.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_src
         assign src_v[gi]   = issue && cmd_q.src_en[gi];
         assign src_idx[gi] = issue ? (src_base[gi] + cnt_idx) : '0;
      end
   endgenerate

   assign O_Idx1_V    = src_v[0];
   assign O_Idx2_V    = src_v[1];
   assign O_Idx3_V    = src_v[2];
   assign O_Idx1      = src_idx[0];
   assign O_Idx2      = src_idx[1];
   assign O_Idx3      = src_idx[2];
   assign O_Dst_V     = issue;
   assign O_Dst       = issue ? (WIDTH_IDX'(cmd_q.dst) + cnt_idx) : '0;
   assign O_Slice_Len = (issue && (cnt_q == '0)) ? len : '0;
   assign O_Cmd_Ready = (state_q == IDLE);
   assign O_Busy      = (state_q != IDLE);

endmodule

// File: doc/bypass_slice_seq.md
Name: bypass_slice_seq

Overview:
- Sequences slice operations through the bypass buffer and register-read path of one TPU lane.
- Accepts one vector command: three source base indices, a destination base and a slice length. Emits one element per cycle: source/destination indices plus the slice-length tag.
- Throttles on force-stall, on buffer-full, and on an in-flight credit limit. Holds off the next command until all write-backs of the current one have retired.

Parameters:
- WIDTH_IDX, 8, width of register/bypass index; index arithmetic wraps modulo 2^WIDTH_IDX.
- WIDTH_LEN, 8, width of slice length field (value = element count - 1).
- MAX_INFLIGHT, 8, maximum issued-but-not-retired elements; power of two, at most 2^WIDTH_LEN.

Ports:
- clock  in  1  clock
- reset  in  1  reset; synchronous, active-high
- I_Cmd_Valid  in  1  command present
- O_Cmd_Ready  out  1  command accepted when Valid & Ready
- I_Cmd_Src_En  in  3  per-source enable, bit k = source k+1
- I_Cmd_Base1/2/3  in  WIDTH_IDX each  source base indices
- I_Cmd_Dst  in  WIDTH_IDX  destination base index
- I_Cmd_Len  in  WIDTH_LEN  element count - 1 (0 = scalar)
- I_Stall  in  1  force stall
- I_Full  in  1  bypass buffer full
- I_WB_Done  in  1  one element write-back retired
- O_Idx1/2/3_V  out  1 each  source index valid
- O_Idx1/2/3  out  WIDTH_IDX each  source index
- O_Dst_V  out  1  destination valid (= issue)
- O_Dst  out  WIDTH_IDX  destination index
- O_Slice_Len  out  WIDTH_LEN  slice length tag
- O_Busy  out  1  state != IDLE
- O_Inflight  out  $clog2(MAX_INFLIGHT)+1  outstanding count
- O_Underflow  out  1  sticky error flag

Behaviour:
- Reset: state IDLE, element counter 0, inflight 0, command registers 0, O_Underflow 0. All *_V outputs 0, O_Busy 0, O_Cmd_Ready 1.
- States:
  - IDLE -> RUN on accept. Command registers are loaded and the element counter Cnt is set to 0.
  - RUN -> DRAIN on the issue with Cnt == Len.
  - DRAIN -> IDLE when next-inflight == 0.
- O_Cmd_Ready = (state == IDLE). A command is never accepted in RUN or DRAIN.
- Issue = RUN & ~I_Stall & ~I_Full & (inflight < MAX_INFLIGHT | I_WB_Done).
- Output qualification:
  - O_IdxK_V = Issue & Src_En[K-1].
  - O_IdxK = BaseK + Cnt, truncated to WIDTH_IDX.
  - O_Dst_V = Issue; O_Dst = Dst + Cnt.
  - Index outputs are 0 when not issuing.
- O_Slice_Len = Len on the issue with Cnt == 0; 0 on every other cycle.
- Cnt increments by 1 on each Issue.
- Latency: accept at cycle T gives first issue at T+1 when unthrottled. Len = N gives N+1 issues in N+1 consecutive unthrottled cycles.
- Inflight counter:
  - +1 on Issue, -1 on I_WB_Done; both in the same cycle leaves it unchanged.
  - I_WB_Done with inflight == 0 and no Issue: count stays 0 and O_Underflow sets (cleared only by reset).
- A stall or full condition mid-slice freezes Cnt; the issue resumes with the same index the next unblocked cycle.
- Len = 0: a single issue with O_Slice_Len = 0, then DRAIN.
- Src_En = 0: destination-only issues; all O_IdxK_V stay 0.
- Reset asserted in any state returns to reset values on the next edge; in-flight elements are discarded without error.

Decomposition:
- pkg_tpu receives:
  - typedef seq_state_t (IDLE, RUN, DRAIN)
  - typedef seq_cmd_t (src_en, base1..3, dst, len)
  - constant MAX_INFLIGHT default
- Sub-module credit_counter holds the up/down inflight count, the limit compare and the underflow flag; parameter MAX.
- Sequencer FSM, command registers and index adders stay in bypass_slice_seq.

Test Plan:
- Reset, then Cmd {En=3'b111, Base=10/20/30, Dst=40, Len=3}:
  - Required: issues at T+1..T+4 with Idx1 = 10..13, Idx2 = 20..23, Idx3 = 30..33, Dst = 40..43.
  - O_Slice_Len = 3 only at T+1.
  - O_Cmd_Ready = 0 until four I_WB_Done pulses are received.
- Len=5 with I_Stall high on cycles 2-3 and I_Full high on cycle 5:
  - Required: exactly six issues, no index skipped or repeated.
  - Outputs frozen (V=0) during blocked cycles.
- MAX_INFLIGHT=8 with Len=15 and no WB_Done:
  - Required: 8 issues, then O_Inflight = 8 and issue halts.
  - A single WB_Done pulse allows exactly one more issue.
- Base1=254, WIDTH_IDX=8, Len=3, En=3'b001:
  - Required: Idx1 = 254, 255, 0, 1 and Idx2_V = Idx3_V = 0 throughout.
- I_WB_Done pulse in IDLE with inflight 0:
  - Required: O_Underflow = 1 next cycle and O_Inflight stays 0.
  - After reset, O_Underflow = 0.
- Reset asserted mid-RUN (after two issues of Len=7):
  - Required: next cycle state IDLE, O_Busy = 0, O_Inflight = 0, O_Cmd_Ready = 1, no further issues.
